serial_subtractor: RTL and testbench

//   Parametrised multi-cycle subtractor: computes diff = a - b - bin over WIDTH bits,

---
 rtl/serial_subtractor.sv | 104 ++++++++++
 tb/tb_serial_subtractor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per clock,
// least-significant digit first, with the borrow carried between digits in a register.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, next;
  logic [WIDTH-1:0]  areg, breg, ashift;
  logic              borrow;
  logic [CW-1:0]     count;
  logic              accept, last;
  logic [DIGIT:0]    dsum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next   = state;
    accept = 1'b0;
    last   = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept = 1'b1;
        next   = RUN;
      end
      RUN: if (count == CW'(N - 1)) begin
        last = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // The top bit of the (DIGIT+1)-bit difference is the digit's borrow-out.
  always_comb begin
    dsum = {1'b0, areg[DIGIT-1:0]} - {1'b0, breg[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
  end

  // Result digits refill the vacated top of the minuend register, so after N
  // shifts it holds the complete difference.
  if (WIDTH > DIGIT) begin : g_shift
    assign ashift = {dsum[DIGIT-1:0], areg[WIDTH-1:DIGIT]};
  end else begin : g_single
    assign ashift = dsum[DIGIT-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      areg   <= '0;
      breg   <= '0;
      borrow <= 1'b0;
      count  <= '0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        areg   <= a;
        breg   <= b;
        borrow <= bin;
        count  <= '0;
      end else if (state == RUN) begin
        areg   <= ashift;
        breg   <= breg >> DIGIT;
        borrow <= dsum[DIGIT];
        count  <= count + 1'b1;
        if (last) begin
          diff <= ashift;
          bout <= dsum[DIGIT];
          zero <= (ashift == '0);
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: three geometries (8/2, 1/1, 16/4)
// compared against plain integer arithmetic.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start8 = 1'b0, bin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, bout8, zero8;
  logic [7:0]  diff8;

  logic        start1 = 1'b0, bin1 = 1'b0;
  logic [0:0]  a1 = '0, b1 = '0;
  logic        busy1, done1, bout1, zero1;
  logic [0:0]  diff1;

  logic        start16 = 1'b0, bin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, bout16, zero16;
  logic [15:0] diff16;

  int tests = 0;
  int fails = 0;

  serial_subtractor #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8));

  serial_subtractor #(.WIDTH(1), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .zero(zero1));

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .zero(zero16));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Packed view of one instance: {busy, done, zero, bout, diff[15:0]}
  function automatic logic [19:0] sample(input int sel);
    case (sel)
      0:       return {busy8, done8, zero8, bout8, 8'h00, diff8};
      1:       return {busy1, done1, zero1, bout1, 15'h0000, diff1};
      default: return {busy16, done16, zero16, bout16, diff16};
    endcase
  endfunction

  task automatic applyStimulus(input int sel, input int ta, input int tb, input int tbin);
    @(negedge clk);
    case (sel)
      0:       begin start8  = 1'b1; a8  = ta[7:0];  b8  = tb[7:0];  bin8  = tbin[0]; end
      1:       begin start1  = 1'b1; a1  = ta[0:0];  b1  = tb[0:0];  bin1  = tbin[0]; end
      default: begin start16 = 1'b1; a16 = ta[15:0]; b16 = tb[15:0]; bin16 = tbin[0]; end
    endcase
    @(negedge clk);
    start8  = 1'b0;
    start1  = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic runOp(input int sel, input int ta, input int tb, input int tbin, input string tag);
    int w, n, mask, ea, eb, eb_in, raw, cycles;
    logic [19:0] s;
    w     = (sel == 0) ? 8 : (sel == 1) ? 1 : 16;
    n     = (sel == 1) ? 1 : 4;
    mask  = (1 << w) - 1;
    ea    = ta & mask;
    eb    = tb & mask;
    eb_in = tbin & 1;
    raw   = ea - eb - eb_in;
    applyStimulus(sel, ea, eb, eb_in);
    s = sample(sel);
    cycles = 1;
    while (!s[18] && cycles < 40) begin
      @(negedge clk);
      cycles++;
      s = sample(sel);
    end
    if (!s[18]) begin
      checkOutput({tag, " timeout"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({tag, " latency"}, cycles - 1, n);
    checkOutput({tag, " diff"}, {16'h0, s[15:0]}, raw & mask);
    checkOutput({tag, " bout"}, {31'h0, s[16]}, (raw < 0) ? 1 : 0);
    checkOutput({tag, " zero"}, {31'h0, s[17]}, ((raw & mask) == 0) ? 1 : 0);
    @(negedge clk);
    s = sample(sel);
    checkOutput({tag, " pulse"}, {31'h0, s[18]}, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [19:0] s;
    int pulses, first, second, consec, cycles, dones;
    logic prevDone;

    #12;
    for (int sel = 0; sel < 3; sel++) begin
      s = sample(sel);
      checkOutput($sformatf("reset state %0d", sel), {12'h0, s}, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    runOp(0, 'h5A, 'h3C, 0, "basic");
    runOp(0, 'h00, 'h01, 0, "underflow");
    runOp(0, 'h01, 'h00, 1, "zero result");

    // start held high: back-to-back accepts every N+1 cycles
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
    pulses = 0; first = 0; second = 0; consec = 0; prevDone = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) start8 = 1'b0;
      s = sample(0);
      if (s[18]) begin
        pulses++;
        if (pulses == 1) first = i;
        else if (pulses == 2) second = i;
        checkOutput("b2b diff", {16'h0, s[15:0]}, 32'h0F);
        if (prevDone) consec++;
      end
      prevDone = s[18];
    end
    checkOutput("b2b pulses", pulses, 2);
    checkOutput("b2b spacing", second - first, 5);
    checkOutput("b2b width", consec, 0);

    // start while busy is ignored
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
    @(negedge clk);
    start8 = 1'b0;
    s = sample(0);
    cycles = 0;
    while (!s[18] && cycles < 20) begin
      @(negedge clk);
      cycles++;
      s = sample(0);
    end
    checkOutput("busy-start done", {31'h0, s[18]}, 1);
    checkOutput("busy-start diff", {16'h0, s[15:0]}, 32'h7F);
    checkOutput("busy-start bout", {31'h0, s[16]}, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    checkOutput("busy-start extra", dones, 0);

    // reset two cycles into RUN aborts the operation
    applyStimulus(0, 'h5A, 'h3C, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    s = sample(0);
    checkOutput("abort outputs", {12'h0, s}, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    checkOutput("abort no done", dones, 0);
    runOp(0, 'h03, 'h05, 0, "post-reset");

    for (int k = 0; k < 8; k++)
      runOp(1, (k >> 2) & 1, (k >> 1) & 1, k & 1, $sformatf("w1 a%0d b%0d bin%0d", (k >> 2) & 1, (k >> 1) & 1, k & 1));

    for (int k = 0; k < 10; k++)
      runOp(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), $sformatf("rand8 %0d", k));

    runOp(2, 'h0000, 'hFFFF, 1, "w16 wrap");
    runOp(2, 'h1234, 'h1234, 0, "w16 equal");
    for (int k = 0; k < 12; k++)
      runOp(2, $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 1), $sformatf("rand16 %0d", k));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
